// File: rtl/hazard_ctrl_md.sv
// rtl/hazard_ctrl_md.sv - ID-stage hazard controller: forwarding, interlocks, mul/div scoreboard, flush
module hazard_ctrl_md #(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic             br_taken,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [RA_W-1:0]  ex_dst,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [RA_W-1:0]  mem_dst,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_if,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [1:0]       fwda_raw, fwdb_raw;
  logic             load_stall, md_stall, stall, md_accept;

  // Select the youngest producer: EX ALU result, then MEM ALU result, then MEM load data.
  function automatic logic [1:0] fwd_sel(
    input logic            use_x,
    input logic [RA_W-1:0] x,
    input logic            e_wreg,
    input logic            e_m2reg,
    input logic [RA_W-1:0] e_dst,
    input logic            m_wreg,
    input logic            m_m2reg,
    input logic [RA_W-1:0] m_dst
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_x) begin
      if (e_wreg && !e_m2reg && (e_dst != '0) && (e_dst == x)) begin
        sel = 2'd1;
      end else if (m_wreg && !m_m2reg && (m_dst != '0) && (m_dst == x)) begin
        sel = 2'd2;
      end else if (m_wreg && m_m2reg && (m_dst != '0) && (m_dst == x)) begin
        sel = 2'd3;
      end
    end
    return sel;
  endfunction

  // Hazard detection and next-state for the mul/div occupancy and stall counter.
  always_comb begin
    fwda_raw = fwd_sel(id_use_rs, id_rs, ex_wreg, ex_m2reg, ex_dst, mem_wreg, mem_m2reg, mem_dst);
    fwdb_raw = fwd_sel(id_use_rt, id_rt, ex_wreg, ex_m2reg, ex_dst, mem_wreg, mem_m2reg, mem_dst);

    load_stall = id_valid && ex_wreg && ex_m2reg && (ex_dst != '0) &&
                 ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt)));
    md_stall   = id_valid && (md_cnt_q != '0) && (id_is_md || id_reads_hilo);
    // Inputs may still look hazardous while reset is held; the pipeline must free-run then.
    stall      = (load_stall || md_stall) && !rst;
    md_accept  = id_valid && id_is_md && !stall;

    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = MD_W'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any mul/div in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Output drive, forced to the free-running pattern while reset is asserted.
  always_comb begin
    fwda         = rst ? 2'd0 : fwda_raw;
    fwdb         = rst ? 2'd0 : fwdb_raw;
    wpcir        = !stall;
    bubble       = stall;
    flush_if     = br_taken && id_valid && !stall && !rst;
    md_busy      = (md_cnt_q != '0) && !rst;
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// tb/tb_hazard_ctrl_md.sv - scoreboard bench for hazard_ctrl_md
module tb_hazard_ctrl_md;

  localparam int RA_W   = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs, id_use_rt, id_is_md, id_reads_hilo, br_taken;
  logic [RA_W-1:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic             ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, bubble, flush_if, md_busy;
  logic [CNT_W-1:0] stall_cycles;

  hazard_ctrl_md #(.RA_W(RA_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo), .br_taken(br_taken),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_dst(ex_dst),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_dst(mem_dst),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
    .flush_if(flush_if), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             wp;
    logic             bub;
    logic             fl;
    logic             busy;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                            input logic wp, input logic bub, input logic fl, input logic busy,
                            input logic [CNT_W-1:0] sc);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.wp = wp; e.bub = bub;
    e.fl = fl; e.busy = busy; e.sc = sc;
    sb.push_back(e);
  endtask

  // Monitor: one expectation is consumed per cycle at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [11:0] act;
    logic [11:0] req;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {fwda, fwdb, wpcir, bubble, flush_if, md_busy, stall_cycles};
      req = {e.fa, e.fb, e.wp, e.bub, e.fl, e.busy, e.sc};
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL %s: got fwda=%0d fwdb=%0d wpcir=%b bubble=%b flush=%b busy=%b sc=%0d, want fwda=%0d fwdb=%0d wpcir=%b bubble=%b flush=%b busy=%b sc=%0d",
                 e.name, fwda, fwdb, wpcir, bubble, flush_if, md_busy, stall_cycles,
                 e.fa, e.fb, e.wp, e.bub, e.fl, e.busy, e.sc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_is_md = 0; id_reads_hilo = 0; br_taken = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_dst = '0;
    mem_wreg = 0; mem_m2reg = 0; mem_dst = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset forces outputs even with hazardous inputs present.
    cyc();
    ex_wreg = 1; ex_m2reg = 1; ex_dst = 5; id_rt = 5; id_use_rt = 1; id_valid = 1;
    id_rs = 7; id_use_rs = 1; mem_wreg = 1; mem_dst = 7; br_taken = 1;
    expect_out("reset_forced", 0, 0, 1, 0, 0, 0, 0);
    cyc(); rst = 0; idle();
    expect_out("idle", 0, 0, 1, 0, 0, 0, 0);

    // Forwarding priority.
    cyc(); idle(); id_valid = 1;
    ex_wreg = 1; ex_dst = 7; mem_wreg = 1; mem_dst = 7; id_rs = 7; id_use_rs = 1;
    expect_out("fwd_ex_wins", 1, 0, 1, 0, 0, 0, 0);
    cyc(); ex_wreg = 0;
    expect_out("fwd_mem_alu", 2, 0, 1, 0, 0, 0, 0);
    cyc(); mem_m2reg = 1;
    expect_out("fwd_mem_load", 3, 0, 1, 0, 0, 0, 0);
    cyc(); id_use_rs = 0; id_rt = 7; id_use_rt = 1;
    expect_out("fwd_rt_only", 0, 3, 1, 0, 0, 0, 0);
    cyc(); idle(); id_valid = 1;
    ex_wreg = 1; mem_wreg = 1; id_use_rs = 1; id_use_rt = 1;
    expect_out("fwd_r0", 0, 0, 1, 0, 0, 0, 0);

    // Load-use interlock.
    cyc(); idle(); id_valid = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_dst = 5; id_rt = 5; id_use_rt = 1;
    expect_out("load_stall_rt", 0, 0, 0, 1, 0, 0, 0);
    cyc(); id_use_rt = 0;
    expect_out("load_no_use", 0, 0, 1, 0, 0, 0, 1);
    cyc(); id_use_rt = 1; ex_dst = 0; id_rt = 0;
    expect_out("load_r0", 0, 0, 1, 0, 0, 0, 1);
    cyc(); ex_dst = 5; id_rt = 5; id_valid = 0;
    expect_out("load_invalid", 0, 0, 1, 0, 0, 0, 1);
    cyc(); id_valid = 1; id_use_rt = 0; id_rs = 5; id_use_rs = 1;
    expect_out("load_stall_rs", 0, 0, 0, 1, 0, 0, 1);

    // Taken branch during stall is held, then flushes once.
    cyc(); br_taken = 1;
    expect_out("br_stalled", 0, 0, 0, 1, 0, 0, 2);
    cyc(); ex_wreg = 0; ex_m2reg = 0;
    expect_out("br_flush", 0, 0, 1, 0, 1, 0, 3);
    cyc(); idle();
    expect_out("br_after", 0, 0, 1, 0, 0, 0, 3);

    // Mul/div occupancy and mfhi interlock.
    cyc(); idle(); id_valid = 1; id_is_md = 1;
    expect_out("md_issue", 0, 0, 1, 0, 0, 0, 3);
    cyc(); idle();
    expect_out("md_busy_n1", 0, 0, 1, 0, 0, 1, 3);
    cyc(); id_valid = 1; id_reads_hilo = 1;
    expect_out("mfhi_stall_n2", 0, 0, 0, 1, 0, 1, 3);
    cyc();
    expect_out("mfhi_stall_n3", 0, 0, 0, 1, 0, 1, 4);
    cyc();
    expect_out("mfhi_stall_n4", 0, 0, 0, 1, 0, 1, 5);
    cyc();
    expect_out("mfhi_accept_n5", 0, 0, 1, 0, 0, 0, 6);
    cyc(); id_reads_hilo = 0; id_is_md = 1;
    expect_out("md_issue2", 0, 0, 1, 0, 0, 0, 6);
    cyc();
    expect_out("md_b2b_stall", 0, 0, 0, 1, 0, 1, 6);

    // Reset mid-operation with md_cnt=3.
    cyc(); rst = 1;
    expect_out("md_reset", 0, 0, 1, 0, 0, 0, 0);
    cyc(); rst = 0;
    expect_out("md_after_reset", 0, 0, 1, 0, 0, 0, 0);
    cyc(); idle();
    expect_out("md_busy_after_reset", 0, 0, 1, 0, 0, 1, 0);

    // Saturating stall counter.
    cyc(); rst = 1; idle();
    expect_out("reset2", 0, 0, 1, 0, 0, 0, 0);
    cyc(); rst = 0; id_valid = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_dst = 9; id_rs = 9; id_use_rs = 1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      expect_out($sformatf("sat_%0d", k), 0, 0, 0, 1, 0, 0, CNT_W'((k > 15) ? 15 : k));
    end
    cyc(); idle();
    expect_out("sat_hold", 0, 0, 1, 0, 0, 0, 15);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sb.size() > 0; w++) cyc();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_md.md
Name: hazard_ctrl_md

Overview:
- Pipeline hazard controller for the 5-stage MIPS core, parametrised in register-address width, mul/div latency and stall-counter width.
- Resolves forwarding selection for ID-stage operands (EX over MEM priority) and load-use interlocks.
- Adds a multi-cycle HI/LO mul/div busy scoreboard, taken-branch IF/ID flush and a saturating stall-cycle performance counter.
- Sits beside the decoder in ID; its outputs drive the IF/ID write enable, the ID/EX bubble mux and the operand forwarding muxes.

Parameters:
- RA_W, 5, register address width.
- MD_LAT, 8, mul/div occupancy in cycles; legal range 1..255.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RA_W  ID source register rs.
- id_rt  in  RA_W  ID source register rt.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_is_md  in  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- br_taken  in  1  branch/jump resolved taken in ID.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- ex_dst  in  RA_W  EX destination register.
- mem_wreg  in  1  MEM instruction writes the register file.
- mem_m2reg  in  1  MEM instruction is a load.
- mem_dst  in  RA_W  MEM destination register.
- fwda  out  2  rs forwarding select.
- fwdb  out  2  rt forwarding select.
- wpcir  out  1  PC and IF/ID write enable; 1 = advance.
- bubble  out  1  zero the ID/EX control signals.
- flush_if  out  1  squash the IF/ID instruction.
- md_busy  out  1  mul/div unit occupied.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: md_cnt=0 and stall_cycles=0, applied asynchronously. While rst is asserted, outputs are forced to fwda=fwdb=0, wpcir=1, bubble=0, flush_if=0 and md_busy=0. Reset mid-operation aborts the mul/div occupancy immediately.
- Forwarding (combinational, per operand X in {rs,rt}; rule 2 is applied before rule 3):
  - 1 if ex_wreg, ex_m2reg=0, ex_dst!=0, ex_dst==X.
  - else 2 if mem_wreg, mem_m2reg=0, mem_dst!=0, mem_dst==X.
  - else 3 if mem_wreg, mem_m2reg=1, mem_dst!=0, mem_dst==X.
  - else 0.
  - When id_use_X=0, the select is 0.
- load_stall = id_valid & ex_wreg & ex_m2reg & ex_dst!=0 & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt)).
- md_stall = id_valid & md_busy & (id_is_md | id_reads_hilo).
- stall = load_stall | md_stall.
  - wpcir = ~stall and bubble = stall.
  - Simultaneous causes produce one stall and one count.
- Mul/div scoreboard:
  - md_cnt is $clog2(MD_LAT+1) bits wide; md_busy = (md_cnt!=0).
  - Accept = id_valid & id_is_md & ~stall. On accept at edge N, md_cnt loads MD_LAT, so md_busy is high for exactly MD_LAT cycles after the edge.
  - Otherwise md_cnt decrements when nonzero.
  - Back-to-back mul/div stalls until md_cnt reaches 0; accept occurs in the first cycle with md_busy=0.
- Branch flush: flush_if = br_taken & id_valid & ~stall.
  - A stalled branch does not flush; it is re-evaluated once the stall clears.
  - flush_if is a single cycle per accepted taken branch.
- Stall counter: increments on every edge where stall=1 and saturates at 2^CNT_W-1. No wrap.
- Destination register 0 never forwards or stalls.
- id_valid=0 suppresses stall, accept and flush. Forwarding still computes.

Test Plan:
- ex_wreg=1, ex_m2reg=0, ex_dst=7 and mem_wreg=1, mem_m2reg=0, mem_dst=7; id_rs=7, use_rs=1 -> fwda=1 (EX wins). With ex_wreg=0 -> fwda=2. Then mem_m2reg=1 -> fwda=3.
- Load in EX, ex_dst=5; id_rt=5, use_rt=1, id_valid=1 -> wpcir=0, bubble=1, stall_cycles +1. With use_rt=0 -> no stall. With ex_dst=0 -> no stall.
- MD_LAT=4: issue mult at edge N -> md_busy=1 for cycles N+1..N+4. mfhi in ID at N+2 -> stalls 3 cycles, accepted at N+4+1 with md_busy=0. stall_cycles=3.
- br_taken=1 during a load-use stall -> flush_if=0. On the next cycle with stall clear -> flush_if=1 for one cycle.
- Assert rst while md_cnt=3 -> md_busy=0 and stall_cycles=0 immediately, wpcir=1. After release, mult is accepted in the first cycle.
- CNT_W=4, hold a load-use stall for 20 cycles -> stall_cycles stops at 15 and does not wrap.
